// File: rtl/wisc_pkg.sv
// wisc_pkg -- shared definitions for the WISC pipeline (decode, ID/EX, execute).
//
// Contents:
//   INSTR_W / REG_IDX_W   instruction word and register index widths
//   OPC_MSB / OPC_LSB     opcode field position inside the instruction word
//   NOP_ENC               instruction encoding used for pipeline bubbles
//   ex_ctrl_t             control bundle carried from decode into execute
//   BUBBLE_CTRL           control bundle value of a bubble (everything off)
//   opcode_of()           extracts the opcode field from an instruction word
package wisc_pkg;

    localparam int INSTR_W   = 16;
    localparam int REG_IDX_W = 3;

    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 11;

    // Opcode 5'b00001 is the architectural NOP.
    localparam logic [INSTR_W-1:0] NOP_ENC = 16'h0800;

    typedef struct packed {
        logic                 valid;
        logic                 wr_en;
        logic                 invA;
        logic                 invB;
        logic                 Cin;
        logic [REG_IDX_W-1:0] wr_reg;
    } ex_ctrl_t;

    // A bubble must never write the register file or perturb the ALU.
    localparam ex_ctrl_t BUBBLE_CTRL = '0;

    function automatic logic [OPC_MSB-OPC_LSB:0] opcode_of(input logic [INSTR_W-1:0] instr);
        return instr[OPC_MSB:OPC_LSB];
    endfunction

endpackage

// File: rtl/pipe_dff.sv
// pipe_dff -- width-parameterised pipeline flop with enable and synchronous reset.
//
// Parameters:
//   W        storage width
//   RST_VAL  value loaded when rst is high
// Ports:
//   clk  in   rising-edge clock
//   rst  in   synchronous active-high reset, overrides en
//   en   in   load d at the edge when high, hold otherwise
//   d    in   W-bit next value
//   q    out  W-bit registered value
module pipe_dff #(
    parameter int           W       = 8,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] r_q_p0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q_p0 <= RST_VAL;
        end else if (en) begin
            r_q_p0 <= d;
        end
    end

    assign q = r_q_p0;

endmodule

// File: rtl/id_ex_reg.sv
// id_ex_reg -- decode/execute pipeline register with stall, flush and bubble insertion.
//
// Parameters:
//   DATA_W     width of pc2 / operand / immediate fields
//   NOP_INSTR  instruction word loaded into ex_instr for a bubble
// Ports:
//   clk, rst                      clock, synchronous active-high reset (loads a bubble)
//   stall                         hold every ex_* output this cycle
//   flush                         load a bubble; wins over stall and id_valid
//   id_valid, id_instr, id_pc2,
//   id_a, id_b, id_imm,
//   id_invA, id_invB, id_Cin,
//   id_wr_en, id_wr_reg           decode-stage entry
//   ex_*                          registered copy of the id_* entry for execute
//   ex_bubble_cnt                 (only with ID_EX_BUBBLE_CNT_EN) saturating count of
//                                 bubbles inserted by flush or id_valid=0
// Optional build macro: ID_EX_BUBBLE_CNT_EN
module id_ex_reg
    import wisc_pkg::*;
#(
    parameter int                 DATA_W    = 16,
    parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_ENC
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic                 flush,
    input  logic                 id_valid,
    input  logic [INSTR_W-1:0]   id_instr,
    input  logic [DATA_W-1:0]    id_pc2,
    input  logic [DATA_W-1:0]    id_a,
    input  logic [DATA_W-1:0]    id_b,
    input  logic [DATA_W-1:0]    id_imm,
    input  logic                 id_invA,
    input  logic                 id_invB,
    input  logic                 id_Cin,
    input  logic                 id_wr_en,
    input  logic [REG_IDX_W-1:0] id_wr_reg,
    output logic                 ex_valid,
    output logic [INSTR_W-1:0]   ex_instr,
    output logic [DATA_W-1:0]    ex_pc2,
    output logic [DATA_W-1:0]    ex_a,
    output logic [DATA_W-1:0]    ex_b,
    output logic [DATA_W-1:0]    ex_imm,
    output logic                 ex_invA,
    output logic                 ex_invB,
    output logic                 ex_Cin,
    output logic                 ex_wr_en,
    output logic [REG_IDX_W-1:0] ex_wr_reg
`ifdef ID_EX_BUBBLE_CNT_EN
    ,
    output logic [15:0]          ex_bubble_cnt
`endif
);

    localparam int DAT_GRP_W = 4 * DATA_W;

    logic                 w_load_bubble;
    logic                 w_en;
    ex_ctrl_t             w_ctrl_d;
    ex_ctrl_t             w_ctrl_q;
    logic [INSTR_W-1:0]   w_instr_d;
    logic [INSTR_W-1:0]   w_instr_q;
    logic [DAT_GRP_W-1:0] w_data_d;
    logic [DAT_GRP_W-1:0] w_data_q;

    // Flush and an empty decode slot both turn the captured entry into a bubble.
    // Flush also re-enables the register so it overrides a concurrent stall.
    assign w_load_bubble = flush | ~id_valid;
    assign w_en          = ~stall | flush;

    always_comb begin
        w_ctrl_d  = BUBBLE_CTRL;
        w_instr_d = NOP_INSTR;
        w_data_d  = '0;
        if (!w_load_bubble) begin
            w_ctrl_d.valid  = 1'b1;
            w_ctrl_d.wr_en  = id_wr_en;
            w_ctrl_d.invA   = id_invA;
            w_ctrl_d.invB   = id_invB;
            w_ctrl_d.Cin    = id_Cin;
            w_ctrl_d.wr_reg = id_wr_reg;
            w_instr_d       = id_instr;
            w_data_d        = {id_pc2, id_a, id_b, id_imm};
        end
    end

    // ---- ID -> EX stage boundary ----
    pipe_dff #(
        .W       ($bits(ex_ctrl_t)),
        .RST_VAL (BUBBLE_CTRL)
    ) u_ctrl_dff (
        .clk (clk),
        .rst (rst),
        .en  (w_en),
        .d   (w_ctrl_d),
        .q   (w_ctrl_q)
    );

    pipe_dff #(
        .W       (INSTR_W),
        .RST_VAL (NOP_INSTR)
    ) u_instr_dff (
        .clk (clk),
        .rst (rst),
        .en  (w_en),
        .d   (w_instr_d),
        .q   (w_instr_q)
    );

    pipe_dff #(
        .W       (DAT_GRP_W),
        .RST_VAL ('0)
    ) u_data_dff (
        .clk (clk),
        .rst (rst),
        .en  (w_en),
        .d   (w_data_d),
        .q   (w_data_q)
    );

    assign ex_valid  = w_ctrl_q.valid;
    assign ex_wr_en  = w_ctrl_q.wr_en;
    assign ex_invA   = w_ctrl_q.invA;
    assign ex_invB   = w_ctrl_q.invB;
    assign ex_Cin    = w_ctrl_q.Cin;
    assign ex_wr_reg = w_ctrl_q.wr_reg;
    assign ex_instr  = w_instr_q;
    assign {ex_pc2, ex_a, ex_b, ex_imm} = w_data_q;

`ifdef ID_EX_BUBBLE_CNT_EN
    logic [15:0] r_bubble_cnt_p0;
    logic        w_bubble_evt;

    // Counts only bubbles that are actually loaded; stalled cycles with
    // id_valid=0 hold the register and are not bubbles.
    assign w_bubble_evt = w_load_bubble & w_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bubble_cnt_p0 <= '0;
        end else if (w_bubble_evt && (r_bubble_cnt_p0 != 16'hFFFF)) begin
            r_bubble_cnt_p0 <= r_bubble_cnt_p0 + 16'd1;
        end
    end

    assign ex_bubble_cnt = r_bubble_cnt_p0;
`endif

endmodule

// File: tb/tb_id_ex_reg.sv
module tb_id_ex_reg;

    localparam int DATA_W = 16;

    logic        clk = 1'b0;
    logic        rst, stall, flush, id_valid;
    logic [15:0] id_instr, id_pc2, id_a, id_b, id_imm;
    logic        id_invA, id_invB, id_Cin, id_wr_en;
    logic [2:0]  id_wr_reg;
    logic        ex_valid, ex_invA, ex_invB, ex_Cin, ex_wr_en;
    logic [15:0] ex_instr, ex_pc2, ex_a, ex_b, ex_imm;
    logic [2:0]  ex_wr_reg;
`ifdef ID_EX_BUBBLE_CNT_EN
    logic [15:0] ex_bubble_cnt;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model: the entry execute should currently see.
    logic        m_valid, m_invA, m_invB, m_Cin, m_wr_en;
    logic [15:0] m_instr, m_pc2, m_a, m_b, m_imm;
    logic [2:0]  m_wr_reg;
    int          m_cnt;

    always #5 clk = ~clk;

    id_ex_reg #(.DATA_W(DATA_W), .NOP_INSTR(16'h0800)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .id_valid(id_valid), .id_instr(id_instr), .id_pc2(id_pc2),
        .id_a(id_a), .id_b(id_b), .id_imm(id_imm),
        .id_invA(id_invA), .id_invB(id_invB), .id_Cin(id_Cin),
        .id_wr_en(id_wr_en), .id_wr_reg(id_wr_reg),
        .ex_valid(ex_valid), .ex_instr(ex_instr), .ex_pc2(ex_pc2),
        .ex_a(ex_a), .ex_b(ex_b), .ex_imm(ex_imm),
        .ex_invA(ex_invA), .ex_invB(ex_invB), .ex_Cin(ex_Cin),
        .ex_wr_en(ex_wr_en), .ex_wr_reg(ex_wr_reg)
`ifdef ID_EX_BUBBLE_CNT_EN
        , .ex_bubble_cnt(ex_bubble_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Rules applied at each rising edge, in priority order.
    task automatic model_edge();
        bit bubble;
        bubble = rst || flush || (!stall && !id_valid);
        if (!rst && (flush || (!stall && !id_valid)) && m_cnt < 65535) m_cnt++;
        if (rst) m_cnt = 0;
        if (bubble) begin
            m_valid = 0; m_instr = 16'h0800; m_wr_en = 0; m_invA = 0; m_invB = 0;
            m_Cin = 0; m_wr_reg = 0; m_a = 0; m_b = 0; m_imm = 0; m_pc2 = 0;
        end else if (!stall) begin
            m_valid = 1; m_instr = id_instr; m_wr_en = id_wr_en; m_invA = id_invA;
            m_invB = id_invB; m_Cin = id_Cin; m_wr_reg = id_wr_reg;
            m_a = id_a; m_b = id_b; m_imm = id_imm; m_pc2 = id_pc2;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".valid"},  32'(ex_valid),  32'(m_valid));
        chk({tag, ".instr"},  32'(ex_instr),  32'(m_instr));
        chk({tag, ".pc2"},    32'(ex_pc2),    32'(m_pc2));
        chk({tag, ".a"},      32'(ex_a),      32'(m_a));
        chk({tag, ".b"},      32'(ex_b),      32'(m_b));
        chk({tag, ".imm"},    32'(ex_imm),    32'(m_imm));
        chk({tag, ".ctl"},    32'({ex_invA, ex_invB, ex_Cin, ex_wr_en, ex_wr_reg}),
                              32'({m_invA, m_invB, m_Cin, m_wr_en, m_wr_reg}));
        chk({tag, ".wr_inv"}, 32'(ex_wr_en & ~ex_valid), 32'd0);
`ifdef ID_EX_BUBBLE_CNT_EN
        chk({tag, ".cnt"},    32'(ex_bubble_cnt), 32'(m_cnt));
`endif
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic set_in(input logic v, input logic [15:0] instr, input logic [15:0] a,
                          input logic [15:0] b, input logic [2:0] ctl, input logic we,
                          input logic [2:0] wreg);
        id_valid = v; id_instr = instr; id_a = a; id_b = b;
        {id_invA, id_invB, id_Cin} = ctl; id_wr_en = we; id_wr_reg = wreg;
        id_pc2 = 16'h0102; id_imm = 16'hFFF0;
    endtask

    task automatic randomize_in();
        id_valid = ($urandom_range(0, 3) != 0);
        id_instr = 16'($urandom); id_pc2 = 16'($urandom); id_a = 16'($urandom);
        id_b = 16'($urandom); id_imm = 16'($urandom);
        {id_invA, id_invB, id_Cin, id_wr_en} = 4'($urandom);
        id_wr_reg = 3'($urandom);
    endtask

    initial begin
        m_cnt = 0;
        rst = 1; stall = 0; flush = 0;
        set_in(1, 16'h1234, 16'h1111, 16'h2222, 3'b111, 1, 3'd5);

        // Reset for two cycles: bubble state regardless of inputs.
        tick("rst0");
        tick("rst1");
        chk("rst_valid", 32'(ex_valid), 32'd0);
        chk("rst_instr", 32'(ex_instr), 32'h0800);
        chk("rst_wr_en", 32'(ex_wr_en), 32'd0);
`ifdef ID_EX_BUBBLE_CNT_EN
        chk("rst_cnt", 32'(ex_bubble_cnt), 32'd0);
`endif

        // Plain capture.
        rst = 0;
        set_in(1, 16'hD9A9, 16'h0005, 16'h0003, 3'b101, 1, 3'd2);
        tick("cap");
        chk("cap_instr", 32'(ex_instr), 32'hD9A9);
        chk("cap_a", 32'(ex_a), 32'h0005);
        chk("cap_b", 32'(ex_b), 32'h0003);
        chk("cap_ctl", 32'({ex_valid, ex_invA, ex_invB, ex_Cin, ex_wr_en, ex_wr_reg}),
            32'({1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 3'd2}));

        // Stall holds across changing inputs; release captures the new entry.
        set_in(1, 16'h4A07, 16'h0007, 16'h0008, 3'b000, 1, 3'd4);
        tick("ld4a07");
        stall = 1;
        set_in(1, 16'h5B01, 16'h0009, 16'h000A, 3'b010, 0, 3'd1);
        for (int i = 0; i < 3; i++) begin
            tick("stall");
            chk("stall_instr", 32'(ex_instr), 32'h4A07);
        end
        stall = 0;
        tick("unstall");
        chk("unstall_instr", 32'(ex_instr), 32'h5B01);

        // Flush beats stall and a valid write.
        stall = 1; flush = 1;
        set_in(1, 16'h7777, 16'h0001, 16'h0002, 3'b111, 1, 3'd7);
        tick("flush_stall");
        chk("flush_wr_en", 32'(ex_wr_en), 32'd0);
        chk("flush_valid", 32'(ex_valid), 32'd0);
        flush = 0; stall = 0;

        // Reset mid-stall discards the held entry.
        set_in(1, 16'h4A07, 16'h0003, 16'h0004, 3'b000, 1, 3'd3);
        tick("ld4a07b");
        stall = 1;
        tick("hold4a07");
        rst = 1;
        tick("rst_stall");
        chk("rst_stall_instr", 32'(ex_instr), 32'h0800);
        rst = 0; stall = 0;
        set_in(1, 16'hC000, 16'h0000, 16'h0000, 3'b000, 0, 3'd0);
        tick("post_rst");
        chk("post_rst_instr", 32'(ex_instr), 32'hC000);

        // id_valid=0 bubble regardless of other fields.
        set_in(0, 16'hFFFF, 16'hFFFF, 16'hFFFF, 3'b111, 1, 3'd7);
        tick("invalid");

        // Randomized traffic; outputs also rechecked after mid-cycle input changes.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            rst   = ($urandom_range(0, 49) == 0);
            stall = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 9) == 0);
            randomize_in();
            #1;
            check_all("nocomb");
            tick("rand");
        end

`ifdef ID_EX_BUBBLE_CNT_EN
        // Saturation of the bubble counter.
        @(negedge clk);
        rst = 0; stall = 0; flush = 0; id_valid = 0;
        for (int i = 0; i < 70000; i++) begin
            @(posedge clk);
            model_edge();
        end
        #1;
        chk("sat_cnt", 32'(ex_bubble_cnt), 32'hFFFF);
        tick("sat_hold");
        chk("sat_hold_cnt", 32'(ex_bubble_cnt), 32'hFFFF);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
